// File: rtl/bus_datapath.sv
// rtl/bus_datapath.sv - shared-bus datapath with ALU, PC, registers and memory-access FSM
// The control sequencer drives the strobes; this block owns the bus mux and the MAR/MDR/MFC handshake.
module bus_datapath #(
  parameter int WIDTH       = 16,
  parameter int NREGS       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       bus_src,
  output logic [WIDTH-1:0] bus_out,
  output logic             src_err,
  input  logic [NREGS-1:0] reg_we,
  input  logic             alu_a_we,
  input  logic             alu_b_we,
  input  logic [2:0]       alu_op,
  input  logic             alu_out_we,
  output logic [3:0]       flags,
  input  logic             pc_load,
  input  logic             pc_inc,
  input  logic             mar_we,
  input  logic             mdr_we,
  input  logic             mem_start,
  input  logic             mem_rw,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_mfc
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_q, b_q, alu_q, pc_q, mar_q, mdr_q;
  logic [3:0]       flags_q;

  state_t           state;
  logic             rw_q;
  logic [CW-1:0]    cnt;

  // Bus mux: register sources sit at 4..4+NREGS-1, anything above is an error.
  always_comb begin
    bus_out = '0;
    src_err = 1'b0;
    case (bus_src)
      4'd0: bus_out = bus_in;
      4'd1: bus_out = alu_q;
      4'd2: bus_out = pc_q;
      4'd3: bus_out = mdr_q;
      default: begin
        src_err = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
          if (bus_src == 4'(4 + i)) begin
            bus_out = regs[i];
            src_err = 1'b0;
          end
        end
      end
    endcase
  end

  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};
  assign dif_ext = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'd1: begin
        // The extra top bit of the difference is the borrow, i.e. A < B unsigned.
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'd2: alu_res = a_q & b_q;
      3'd3: alu_res = a_q | b_q;
      3'd4: alu_res = a_q ^ b_q;
      3'd5: alu_res = ~a_q;
      3'd6: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      default: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      flags_q <= '0;
      pc_q    <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_we[i]) regs[i] <= bus_out;
      end
      if (alu_a_we) a_q <= bus_out;
      if (alu_b_we) b_q <= bus_out;
      if (alu_out_we) begin
        alu_q   <= alu_res;
        flags_q <= {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
      end
      if (pc_load)     pc_q <= bus_out;
      else if (pc_inc) pc_q <= pc_q + 1'b1;
    end
  end

  // MAR/MDR are frozen during WAIT so the address and write data stay stable;
  // a completing read overrides any concurrent mdr_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (mar_we && state != S_WAIT) mar_q <= bus_out;
      if (state == S_WAIT && mem_mfc && rw_q) mdr_q <= mem_rdata;
      else if (mdr_we && state != S_WAIT) mdr_q <= bus_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rw_q     <= 1'b0;
      cnt      <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_busy <= 1'b0;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_done <= 1'b0;
          if (mem_start) begin
            state    <= S_WAIT;
            rw_q     <= mem_rw;
            cnt      <= '0;
            mem_en   <= 1'b1;
            mem_we   <= !mem_rw;
            mem_busy <= 1'b1;
            mem_err  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_mfc) begin
            state    <= S_DONE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_busy <= 1'b0;
            mem_done <= 1'b1;
          end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
            state    <= S_IDLE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_busy <= 1'b0;
            mem_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          mem_done <= 1'b0;
        end
      endcase
    end
  end

  assign flags     = flags_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_bus_datapath.sv
// tb/tb_bus_datapath.sv - self-checking bench for bus_datapath
// ALU vector table, randomized ALU/register traffic against a reference model, and memory FSM sequences.
module tb_bus_datapath;

  localparam int WIDTH = 16;
  localparam int NREGS = 4;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] bus_in;
  logic [3:0]       bus_src;
  logic [WIDTH-1:0] bus_out;
  logic             src_err;
  logic [NREGS-1:0] reg_we;
  logic             alu_a_we, alu_b_we, alu_out_we;
  logic [2:0]       alu_op;
  logic [3:0]       flags;
  logic             pc_load, pc_inc, mar_we, mdr_we;
  logic             mem_start, mem_rw;
  logic             mem_busy, mem_done, mem_err, mem_en, mem_we;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic             mem_mfc;

  bus_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_src(bus_src), .bus_out(bus_out),
    .src_err(src_err), .reg_we(reg_we), .alu_a_we(alu_a_we), .alu_b_we(alu_b_we),
    .alu_op(alu_op), .alu_out_we(alu_out_we), .flags(flags), .pc_load(pc_load),
    .pc_inc(pc_inc), .mar_we(mar_we), .mdr_we(mdr_we), .mem_start(mem_start),
    .mem_rw(mem_rw), .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         op;
    int         a;
    int         b;
    int         exp_r;
    logic [3:0] exp_f;
  } alu_vec_t;

  alu_vec_t vecs [11];
  int       mreg [NREGS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    reg_we = '0; alu_a_we = 0; alu_b_we = 0; alu_out_we = 0;
    pc_load = 0; pc_inc = 0; mar_we = 0; mdr_we = 0; mem_start = 0; mem_mfc = 0;
  endtask

  task automatic peek(input logic [3:0] src);
    bus_src = src;
    #1;
  endtask

  task automatic drive_bus(input int val);
    bus_src = 4'd0;
    bus_in  = WIDTH'(val);
  endtask

  // Reference ALU from the arithmetic definitions, using plain integers.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output logic [3:0] f);
    int   sa, sb, sr, full;
    logic c, v;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c = 0; v = 0; r = 0;
    case (op)
      0: begin full = a + b; r = full % 65536; c = (full > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      1: begin r = (a - b + 65536) % 65536; c = (a < b); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - a;
      6: begin r = (a * 2) % 65536; c = (a >= 32768); end
      default: begin r = a / 2; c = (a % 2) == 1; end
    endcase
    f = {(r == 0), (r >= 32768), c, v};
  endfunction

  task automatic run_alu(input int op, input int a, input int b);
    drive_bus(a); alu_a_we = 1; tick(); alu_a_we = 0;
    drive_bus(b); alu_b_we = 1; tick(); alu_b_we = 0;
    alu_op = 3'(op); alu_out_we = 1; tick(); alu_out_we = 0;
    peek(4'd1);
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 65535;
      2: return 32768;
      3: return 32767;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    int         r, en_cycles, a, b, op, k;
    logic [3:0] f;
    logic       done_seen;

    vecs[0]  = '{0, 'h7FFF, 'h0001, 'h8000, 4'b0101};
    vecs[1]  = '{1, 'h0005, 'h0005, 'h0000, 4'b1000};
    vecs[2]  = '{7, 'h0001, 'h0000, 'h0000, 4'b1010};
    vecs[3]  = '{0, 'hFFFF, 'h0001, 'h0000, 4'b1010};
    vecs[4]  = '{1, 'h0000, 'h0001, 'hFFFF, 4'b0110};
    vecs[5]  = '{1, 'h8000, 'h0001, 'h7FFF, 4'b0001};
    vecs[6]  = '{2, 'hF0F0, 'h0FF0, 'h00F0, 4'b0000};
    vecs[7]  = '{3, 'h1200, 'h0034, 'h1234, 4'b0000};
    vecs[8]  = '{4, 'hAAAA, 'hAAAA, 'h0000, 4'b1000};
    vecs[9]  = '{5, 'h00FF, 'h0000, 'hFF00, 4'b0100};
    vecs[10] = '{6, 'h8001, 'h0000, 'h0002, 4'b0010};

    clear_strobes();
    rst = 1; bus_in = '0; bus_src = '0; alu_op = '0; mem_rw = 0; mem_rdata = '0;
    tick(); tick();
    rst = 0;

    for (int s = 1; s < 4 + NREGS; s++) begin
      peek(4'(s));
      check($sformatf("reset_src%0d", s), bus_out, 0);
    end
    check("reset_flags", flags, 0);
    check("reset_mem", {mem_en, mem_we, mem_busy, mem_done, mem_err}, 0);

    drive_bus('h1234); reg_we = 4'b0001; tick(); reg_we = 0;
    peek(4'd4);
    check("r0_readback", bus_out, 'h1234);
    peek(4'd15);
    check("src15_bus", bus_out, 0);
    check("src15_err", src_err, 1);
    peek(4'd8);
    check("src8_err", src_err, 1);
    peek(4'd7);
    check("src7_err", src_err, 0);

    for (int i = 0; i < 11; i++) begin
      run_alu(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("alu_vec%0d_out", i), bus_out, vecs[i].exp_r);
      check($sformatf("alu_vec%0d_flags", i), flags, vecs[i].exp_f);
    end

    for (int i = 0; i < 40; i++) begin
      a = pick_val(); b = pick_val(); op = int'($urandom_range(0, 7));
      run_alu(op, a, b);
      ref_alu(op, a, b, r, f);
      check($sformatf("alu_rand%0d_op%0d_out", i, op), bus_out, r);
      check($sformatf("alu_rand%0d_op%0d_flags", i, op), flags, f);
    end

    for (int i = 0; i < NREGS; i++) mreg[i] = 0;
    mreg[0] = 'h1234;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 65535));
      reg_we = NREGS'($urandom_range(0, (1 << NREGS) - 1));
      drive_bus(a);
      for (int j = 0; j < NREGS; j++) if (reg_we[j]) mreg[j] = a;
      tick(); reg_we = 0;
    end
    k = int'($urandom_range(0, NREGS - 1));
    bus_src = 4'(4 + k); reg_we = '1; tick(); reg_we = 0;
    a = mreg[k];
    for (int j = 0; j < NREGS; j++) mreg[j] = a;
    for (int j = 0; j < NREGS; j++) begin
      peek(4'(4 + j));
      check($sformatf("reg%0d_final", j), bus_out, mreg[j]);
    end

    drive_bus('hFFFF); pc_load = 1; tick(); pc_load = 0;
    pc_inc = 1; tick(); pc_inc = 0;
    peek(4'd2);
    check("pc_wrap", bus_out, 0);
    drive_bus('h0100); pc_load = 1; pc_inc = 1; tick(); pc_load = 0; pc_inc = 0;
    peek(4'd2);
    check("pc_load_prio", bus_out, 'h0100);
    pc_inc = 1; tick(); pc_inc = 0;
    peek(4'd2);
    check("pc_inc", bus_out, 'h0101);

    drive_bus('h0040); mar_we = 1; tick(); mar_we = 0;
    mem_rw = 1; mem_start = 1; tick(); mem_start = 0;
    check("rd_busy", mem_busy, 1);
    check("rd_we_low", mem_we, 0);
    en_cycles = 0; done_seen = 0;
    for (int i = 0; i < 30 && !done_seen; i++) begin
      if (mem_en) en_cycles++;
      if (mem_done) done_seen = 1;
      else begin
        mar_we = (i == 1); mdr_we = (en_cycles == 4);
        drive_bus((i == 1) ? 'h9999 : 'h2222);
        mem_mfc = (en_cycles == 4); mem_rdata = 'hBEEF;
        tick();
        mar_we = 0; mdr_we = 0; mem_mfc = 0;
      end
    end
    check("rd_done_seen", done_seen, 1);
    check("rd_en_cycles", en_cycles, 4);
    check("rd_addr_held", mem_addr, 'h0040);
    mem_start = 1; tick(); mem_start = 0;
    check("rd_done_one_cycle", mem_done, 0);
    check("rd_start_in_done_ignored", mem_en, 0);
    peek(4'd3);
    check("rd_mdr", bus_out, 'hBEEF);

    drive_bus('h5555); mdr_we = 1; tick(); mdr_we = 0;
    drive_bus('h0080); mar_we = 1; mem_rw = 0; mem_start = 1; tick();
    mar_we = 0; mem_start = 0;
    check("wr_addr_new_mar", mem_addr, 'h0080);
    en_cycles = 0;
    for (int i = 0; i < 40 && mem_en; i++) begin
      en_cycles++;
      if (!mem_we) check("wr_we_high", mem_we, 1);
      drive_bus('h1111); mdr_we = (i == 2);
      tick(); mdr_we = 0;
    end
    check("wr_timeout_cycles", en_cycles, TMO);
    check("wr_err", mem_err, 1);
    check("wr_idle", mem_busy, 0);
    check("wr_wdata_held", mem_wdata, 'h5555);
    mem_mfc = 1; tick(); mem_mfc = 0;
    check("mfc_idle_ignored", {mem_done, mem_err}, 2'b01);

    mem_rw = 1; mem_start = 1; tick(); mem_start = 0;
    check("err_cleared", mem_err, 0);
    check("restart_en", mem_en, 1);
    rst = 1; tick(); rst = 0;
    check("rst_abort_en", mem_en, 0);
    check("rst_abort_busy", mem_busy, 0);
    mem_rdata = 'hBEEF; mem_mfc = 1; tick(); mem_mfc = 0;
    check("post_rst_mfc_done", mem_done, 0);
    check("post_rst_mfc_en", mem_en, 0);
    peek(4'd3);
    check("post_rst_mdr", bus_out, 0);
    peek(4'd4);
    check("post_rst_r0", bus_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Parametrised successor to the microcontroller's bus datapath.
- Single shared internal bus, implemented as a mux; no tri-states. Bus sources: external input, ALU output register, PC, MDR, NREGS general registers.
- Adds ALU status flags, a PC with load and increment, and a memory-access FSM. The FSM runs the MAR/MDR/MFC handshake with a timeout.
- Sits between the control sequencer, which drives the strobes, and the external memory.

Parameters:
WIDTH, 16, data, address and register width
NREGS, 4, number of general-purpose registers (1..12)
MEM_TIMEOUT, 15, max cycles to wait for mem_mfc before error (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
bus_in  in  WIDTH  externally supplied bus value (immediates/instruction)
bus_src  in  4  bus driver select: 0 bus_in, 1 ALU out reg, 2 PC, 3 MDR, 4+n reg Rn
bus_out  out  WIDTH  current internal bus value (combinational)
src_err  out  1  bus_src selects no existing source (combinational)
reg_we  in  NREGS  per-register latch enable from bus
alu_a_we, alu_b_we  in  1 each  latch bus into ALU operand A / B
alu_op  in  3  ALU operation
alu_out_we  in  1  latch ALU result and flags
flags  out  4  {Z,N,C,V} of last latched result
pc_load, pc_inc  in  1 each  PC load from bus / increment
mar_we, mdr_we  in  1 each  latch bus into MAR / MDR
mem_start  in  1  start a memory access
mem_rw  in  1  1 = read, 0 = write (sampled with mem_start)
mem_busy, mem_done, mem_err  out  1 each  FSM status
mem_en  out  1  memory enable
mem_we  out  1  memory write strobe
mem_addr, mem_wdata  out  WIDTH  driven from MAR / MDR
mem_rdata  in  WIDTH  memory read data
mem_mfc  in  1  memory function complete

Behaviour:
- Reset:
  - All registers, A, B, ALU out, PC, MAR, MDR and flags go to 0.
  - FSM goes to IDLE. mem_en, mem_we, mem_busy, mem_done and mem_err go to 0.
  - Reset mid-access aborts the access: mem_en is 0 after the reset edge.
- Bus mux:
  - bus_out equals the selected source.
  - bus_src >= 4+NREGS: bus_out = 0 and src_err = 1 in the same cycle.
- Latches: every *_we captures bus_out at the edge. Several latches may load in the same cycle, and a register may load its own value.
- ALU (combinational from A and B; result and flags registered only on alu_out_we):
  - Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical).
  - Z: result == 0. N: result MSB.
  - C: ADD carry-out; SUB 1 iff A < B unsigned; shifts give the bit shifted out; others 0.
  - V: signed overflow for ADD/SUB, else 0.
  - Arithmetic is modulo 2^WIDTH.
- PC:
  - pc_load has priority over pc_inc.
  - Increment wraps from all-ones to 0.
- Memory FSM (IDLE, WAIT, DONE):
  - IDLE: mem_start=1 captures mem_rw and moves to WAIT next edge. mem_err clears on that start.
  - WAIT:
    - mem_en=1, mem_we = !captured rw, mem_busy=1.
    - mem_addr = MAR and mem_wdata = MDR, held stable.
    - mar_we and mdr_we are ignored while busy.
  - WAIT with mem_mfc=1 moves to DONE. On a read, MDR <= mem_rdata on that edge.
  - Timeout: if MEM_TIMEOUT consecutive WAIT cycles pass without mem_mfc, go to IDLE and set mem_err=1. mem_err is sticky until rst or the next mem_start. Counter resets on entry to WAIT.
  - DONE: mem_done=1 for exactly one cycle, mem_en=0, then IDLE. mem_start in DONE is ignored.
  - mem_start while busy is ignored.
  - mem_mfc outside WAIT is ignored.
  - Latency: start edge to mem_en high = 1 cycle. MFC to mem_done = 1 cycle.
- Simultaneous events:
  - Read completion and mdr_we in the same cycle: memory data wins.
  - mem_start together with mar_we/mdr_we in IDLE: the latches load, and the access uses the newly loaded MAR/MDR, because addr/data are driven from the registers from the WAIT cycle onward.

Test Plan:
- Reset, then bus_src=0 with bus_in=0x1234 and reg_we=0001 -> R0=0x1234. bus_src=4 -> bus_out=0x1234. bus_src=15 (NREGS=4) -> bus_out=0, src_err=1.
- ALU:
  - A=0x7FFF, B=0x0001, ADD -> out=0x8000, flags Z0 N1 C0 V1.
  - SUB with A=B=5 -> 0, Z1 C0.
  - SHR A=0x0001 -> 0, Z1 C1.
- PC:
  - Load 0xFFFF then pc_inc -> PC=0x0000.
  - pc_load and pc_inc together with bus=0x0100 -> PC=0x0100.
- Memory read:
  - MAR=0x0040, start with rw=1, mfc after 3 cycles with rdata=0xBEEF.
  - Required: mem_en high for 4 cycles, MDR=0xBEEF, one-cycle mem_done, mar_we during WAIT has no effect.
- Memory write with mem_mfc never asserted:
  - mem_we high, mem_err=1 and IDLE after MEM_TIMEOUT=15 WAIT cycles.
  - Next mem_start clears mem_err.
- Assert rst during WAIT -> FSM IDLE and mem_en=0 next cycle. A later mem_mfc pulse has no effect.
